// File: rtl/mouse_pkg.sv
// Shared state encoding, PS/2 command/response bytes and cursor record for the mouse sequencer.
// MOUSE_SAMPLE_RATE_EN adds the set-sample-rate states to the encoding.
package mouse_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_RST,
      S_WAIT_ACK_RST,
      S_WAIT_BAT,
      S_WAIT_ID,
`ifdef MOUSE_SAMPLE_RATE_EN
      S_SEND_RATE,
      S_WAIT_ACK_RATE,
      S_SEND_ARG,
      S_WAIT_ACK_ARG,
`endif
      S_SEND_EN,
      S_WAIT_ACK_EN,
      S_STREAM,
      S_FAIL
   } state_t;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] CMD_RATE   = 8'hF3;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_RESEND = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK = 8'hAA;
   localparam logic [7:0] RSP_ID     = 8'h00;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic       l;
      logic       r;
      logic       m;
   } cursor_t;

endpackage

// File: rtl/mouse_init_ctrl_if.sv
// Byte-level link between the mouse sequencer (master) and the PS/2 transceiver (slave).
interface mouse_init_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;

   modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, rx_error);
   modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, rx_error);
endinterface

// File: rtl/mouse_packet_accum.sv
// Assembles 3-byte PS/2 movement packets and applies them to a clamped cursor position.
module mouse_packet_accum
   import mouse_pkg::*;
#(
   parameter int X_MAX      = 160,
   parameter int Y_MAX      = 120,
   parameter int GAP_CYCLES = 100_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       active,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_error,
   output logic [7:0] x,
   output logic [7:0] y,
   output logic       l_click,
   output logic       r_click,
   output logic       m_click,
   output logic       packet_valid
);

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic signed [10:0] X_LIM = 11'(X_MAX - 1);
   localparam logic signed [10:0] Y_LIM = 11'(Y_MAX - 1);

   logic [1:0]         idx;
   logic [7:0]         b0, b1;
   logic [GW-1:0]      gap_cnt;
   logic signed [10:0] dx, dy, xs, ys;
   cursor_t            cur, cur_nxt;

   // byte2 is consumed straight off rx_data so the update lands one cycle after it arrives
   always_comb begin
      dx = b0[6] ? 11'sd0 : {{3{b0[4]}}, b1};
      dy = b0[7] ? 11'sd0 : {{3{b0[5]}}, rx_data};
      xs = $signed({3'b000, cur.x}) + dx;
      ys = $signed({3'b000, cur.y}) - dy;
      cur_nxt.x = (xs < 11'sd0) ? 8'd0 : (xs > X_LIM) ? X_LIM[7:0] : xs[7:0];
      cur_nxt.y = (ys < 11'sd0) ? 8'd0 : (ys > Y_LIM) ? Y_LIM[7:0] : ys[7:0];
      cur_nxt.l = b0[0];
      cur_nxt.r = b0[1];
      cur_nxt.m = b0[2];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx          <= '0;
         b0           <= '0;
         b1           <= '0;
         gap_cnt      <= '0;
         packet_valid <= 1'b0;
         cur          <= '{x: 8'(X_MAX / 2), y: 8'(Y_MAX / 2), l: 1'b0, r: 1'b0, m: 1'b0};
      end else begin
         packet_valid <= 1'b0;
         if (!active || rx_error) begin
            idx     <= '0;
            gap_cnt <= '0;
         end else if (rx_valid) begin
            gap_cnt <= '0;
            case (idx)
               // bit3 is always set in a real header byte; anything else means we are out of sync
               2'd0: if (rx_data[3]) begin
                  b0  <= rx_data;
                  idx <= 2'd1;
               end
               2'd1: begin
                  b1  <= rx_data;
                  idx <= 2'd2;
               end
               default: begin
                  idx          <= '0;
                  cur          <= cur_nxt;
                  packet_valid <= 1'b1;
               end
            endcase
         end else if (idx != 2'd0) begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
               idx     <= '0;
               gap_cnt <= '0;
            end else begin
               gap_cnt <= gap_cnt + GW'(1);
            end
         end
      end
   end

   assign x       = cur.x;
   assign y       = cur.y;
   assign l_click = cur.l;
   assign r_click = cur.r;
   assign m_click = cur.m;

endmodule

// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse host sequencer: reset/BAT/ID/enable handshake with retries, then streams cursor updates.
// Define MOUSE_SAMPLE_RATE_EN to also program the sample rate (SAMPLE_RATE) before enabling reporting.
module mouse_init_ctrl
   import mouse_pkg::*;
#(
`ifdef MOUSE_SAMPLE_RATE_EN
   parameter logic [7:0] SAMPLE_RATE = 8'd100,
`endif
   parameter int X_MAX          = 160,
   parameter int Y_MAX          = 120,
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int GAP_CYCLES     = 100_000,
   parameter int RETRY_MAX      = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   mouse_init_ctrl_if.master  ps2,
   output logic [7:0]         x,
   output logic [7:0]         y,
   output logic               l_click,
   output logic               r_click,
   output logic               m_click,
   output logic               packet_valid,
   output logic               ready,
   output logic               init_fail
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW    = $clog2(RETRY_MAX + 1);

   state_t           state, ok_st, rs_st, sent_st;
   logic             is_wait, is_ack, ok_send;
   logic [7:0]       exp_byte, ok_cmd, rs_cmd;
   logic [CNT_W-1:0] wait_cnt;
   logic [RW-1:0]    retry_cnt;
   logic             timeout, rx_good, rx_resend, wait_fail, out_of_retries, stream_en;

   // Per-state decode: expected reply, where a good reply leads, and what a resend re-issues
   always_comb begin
      is_wait  = 1'b0;
      is_ack   = 1'b0;
      ok_send  = 1'b0;
      exp_byte = RSP_ACK;
      ok_st    = state;
      ok_cmd   = CMD_RESET;
      rs_st    = S_SEND_RST;
      rs_cmd   = CMD_RESET;
      sent_st  = state;
      case (state)
         S_SEND_RST:     sent_st = S_WAIT_ACK_RST;
         S_WAIT_ACK_RST: begin is_wait = 1'b1; is_ack = 1'b1; ok_st = S_WAIT_BAT; end
         S_WAIT_BAT:     begin is_wait = 1'b1; exp_byte = RSP_BAT_OK; ok_st = S_WAIT_ID; end
         S_WAIT_ID: begin
            is_wait  = 1'b1;
            exp_byte = RSP_ID;
            ok_send  = 1'b1;
`ifdef MOUSE_SAMPLE_RATE_EN
            ok_st    = S_SEND_RATE;
            ok_cmd   = CMD_RATE;
`else
            ok_st    = S_SEND_EN;
            ok_cmd   = CMD_ENABLE;
`endif
         end
`ifdef MOUSE_SAMPLE_RATE_EN
         S_SEND_RATE:    sent_st = S_WAIT_ACK_RATE;
         S_WAIT_ACK_RATE: begin
            is_wait = 1'b1; is_ack = 1'b1; ok_send = 1'b1;
            ok_st   = S_SEND_ARG; ok_cmd = SAMPLE_RATE;
            rs_st   = S_SEND_RATE; rs_cmd = CMD_RATE;
         end
         S_SEND_ARG:     sent_st = S_WAIT_ACK_ARG;
         S_WAIT_ACK_ARG: begin
            is_wait = 1'b1; is_ack = 1'b1; ok_send = 1'b1;
            ok_st   = S_SEND_EN; ok_cmd = CMD_ENABLE;
            rs_st   = S_SEND_ARG; rs_cmd = SAMPLE_RATE;
         end
`endif
         S_SEND_EN:      sent_st = S_WAIT_ACK_EN;
         S_WAIT_ACK_EN: begin
            is_wait = 1'b1; is_ack = 1'b1;
            ok_st   = S_STREAM;
            rs_st   = S_SEND_EN; rs_cmd = CMD_ENABLE;
         end
         default: ;
      endcase
   end

   // A received byte always wins over a same-cycle timeout
   assign timeout        = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign rx_good        = is_wait && ps2.rx_valid && !ps2.rx_error && (ps2.rx_data == exp_byte);
   assign rx_resend      = is_ack && ps2.rx_valid && !ps2.rx_error && (ps2.rx_data == RSP_RESEND);
   assign wait_fail      = is_wait && !rx_good && !rx_resend && (ps2.rx_valid || ps2.rx_error || timeout);
   assign out_of_retries = (retry_cnt == RW'(RETRY_MAX - 1));
   assign stream_en      = enable && (state == S_STREAM);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         retry_cnt    <= '0;
         wait_cnt     <= '0;
         ps2.tx_valid <= 1'b0;
         ps2.tx_data  <= '0;
         ready        <= 1'b0;
         init_fail    <= 1'b0;
      end else if (!enable) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         ps2.tx_valid <= 1'b0;
         ready        <= 1'b0;
      end else begin
         wait_cnt <= is_wait ? wait_cnt + CNT_W'(1) : '0;
         case (state)
            S_IDLE: begin
               state        <= S_SEND_RST;
               retry_cnt    <= '0;
               ps2.tx_valid <= 1'b1;
               ps2.tx_data  <= CMD_RESET;
            end
            S_STREAM, S_FAIL: ;
            default: begin
               if (!is_wait) begin
                  if (ps2.tx_valid && ps2.tx_ready) begin
                     ps2.tx_valid <= 1'b0;
                     state        <= sent_st;
                  end
               end else if (rx_good) begin
                  state        <= ok_st;
                  wait_cnt     <= '0;
                  ps2.tx_valid <= ok_send;
                  if (ok_send) ps2.tx_data <= ok_cmd;
                  if (ok_st == S_STREAM) begin
                     ready     <= 1'b1;
                     retry_cnt <= '0;
                  end
               end else if (rx_resend || wait_fail) begin
                  wait_cnt <= '0;
                  if (out_of_retries) begin
                     state        <= S_FAIL;
                     init_fail    <= 1'b1;
                     ps2.tx_valid <= 1'b0;
                  end else begin
                     retry_cnt    <= retry_cnt + RW'(1);
                     state        <= rx_resend ? rs_st : S_SEND_RST;
                     ps2.tx_valid <= 1'b1;
                     ps2.tx_data  <= rx_resend ? rs_cmd : CMD_RESET;
                  end
               end
            end
         endcase
      end
   end

   mouse_packet_accum #(
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX),
      .GAP_CYCLES (GAP_CYCLES)
   ) u_accum (
      .clock        (clock),
      .reset        (reset),
      .active       (stream_en),
      .rx_data      (ps2.rx_data),
      .rx_valid     (ps2.rx_valid),
      .rx_error     (ps2.rx_error),
      .x            (x),
      .y            (y),
      .l_click      (l_click),
      .r_click      (r_click),
      .m_click      (m_click),
      .packet_valid (packet_valid)
   );

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Directed + randomized bench for mouse_init_ctrl with a simple cursor/transceiver reference model.
module tb_mouse_init_ctrl;

   localparam int XM  = 160;
   localparam int YM  = 120;
   localparam int TO  = 200;
   localparam int GAP = 40;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] x, y;
   logic       l_click, r_click, m_click, packet_valid, ready, init_fail;

   int         checks = 0;
   int         failures = 0;
   int         pv_cnt = 0;
   logic [7:0] txq[$];
   int         mx = XM / 2;
   int         my = YM / 2;
   logic [2:0] mbtn = 3'b000;

   mouse_init_ctrl_if bus();

   mouse_init_ctrl #(
      .X_MAX(XM), .Y_MAX(YM), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .RETRY_MAX(3)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .ps2(bus),
      .x(x), .y(y), .l_click(l_click), .r_click(r_click), .m_click(m_click),
      .packet_valid(packet_valid), .ready(ready), .init_fail(init_fail)
   );

   always #5 clock = ~clock;

   // Transceiver side: log every command byte handed over, and count update pulses
   always @(negedge clock) begin
      if (reset && enable && bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
      if (packet_valid === 1'b1) pv_cnt++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic err);
      @(posedge clock); #1;
      bus.rx_data = b; bus.rx_valid = 1'b1; bus.rx_error = err;
      @(posedge clock); #1;
      bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
   endtask

   task automatic expect_tx(input logic [7:0] cmd, input string tag);
      int n = 0;
      while (txq.size() == 0 && n < 1000) begin
         @(negedge clock); #1;
         n++;
      end
      chk({tag, "_seen"}, 16'(txq.size() != 0), 16'd1);
      if (txq.size() != 0) chk(tag, 16'(txq.pop_front()), 16'(cmd));
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic do_init(input string tag);
      expect_tx(8'hFF, {tag, "_rst"});
      send_rx(8'hFA, 1'b0);
      send_rx(8'hAA, 1'b0);
      send_rx(8'h00, 1'b0);
`ifdef MOUSE_SAMPLE_RATE_EN
      expect_tx(8'hF3, {tag, "_rate"});
      send_rx(8'hFA, 1'b0);
      expect_tx(8'd100, {tag, "_arg"});
      send_rx(8'hFA, 1'b0);
`endif
      expect_tx(8'hF4, {tag, "_en"});
      send_rx(8'hFA, 1'b0);
      @(negedge clock);
      chk({tag, "_ready"}, 16'(ready), 16'd1);
      chk({tag, "_nofail"}, 16'(init_fail), 16'd0);
   endtask

   // Reference: signed 9-bit deltas, overflow bit zeroes the axis, y grows downward
   task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input string tag);
      int dx, dy, p0;
      p0 = pv_cnt;
      send_rx(b0, 1'b0);
      send_rx(b1, 1'b0);
      send_rx(b2, 1'b0);
      dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
      dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
      mx = clampi(mx + dx, 0, XM - 1);
      my = clampi(my - dy, 0, YM - 1);
      mbtn = {b0[2], b0[1], b0[0]};
      @(negedge clock);
      chk({tag, "_x"}, 16'(x), 16'(mx));
      chk({tag, "_y"}, 16'(y), 16'(my));
      chk({tag, "_btn"}, 16'({m_click, r_click, l_click}), 16'(mbtn));
      chk({tag, "_pv_hi"}, 16'(packet_valid), 16'd1);
      @(negedge clock);
      chk({tag, "_pv_once"}, 16'(pv_cnt - p0), 16'd1);
   endtask

   initial begin
      int p0, n;
      bus.tx_ready = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
      tick(3);
      @(negedge clock);
      chk("rst_x", 16'(x), 16'd80);
      chk("rst_y", 16'(y), 16'd60);
      chk("rst_btn_pv", 16'({l_click, r_click, m_click, packet_valid}), 16'd0);
      chk("rst_rdy_fail", 16'({ready, init_fail}), 16'd0);
      chk("rst_tx", 16'({bus.tx_valid, bus.tx_data}), 16'd0);

      // normal bring-up and movement
      tick(1);
      reset = 1'b1; enable = 1'b1; bus.tx_ready = 1'b1;
      do_init("init");
      pkt(8'h08, 8'h0A, 8'h05, "move");
      pkt(8'h19, 8'h80, 8'h00, "clamp_lo");
      pkt(8'h09, 8'h00, 8'h00, "lbtn");

      // resync: header without bit3 must be ignored
      p0 = pv_cnt;
      send_rx(8'h00, 1'b0);
      pkt(8'h08, 8'h01, 8'h01, "resync");
      chk("resync_count", 16'(pv_cnt - p0), 16'd1);

      // idle gap drops the partial packet
      send_rx(8'h18, 1'b0);
      tick(GAP + 5);
      pkt(8'h08, 8'h03, 8'h02, "gap");

      // rx_error mid-packet drops the partial packet
      send_rx(8'h08, 1'b0);
      send_rx(8'h55, 1'b1);
      pkt(8'h0A, 8'hF0, 8'h7F, "rxerr");

      for (int i = 0; i < 24; i++)
         pkt(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom), "rand");

      // enable low: leave streaming, cursor holds
      enable = 1'b0;
      tick(2);
      @(negedge clock);
      chk("dis_ready", 16'(ready), 16'd0);
      chk("dis_x_hold", 16'(x), 16'(mx));
      chk("dis_y_hold", 16'(y), 16'(my));
      enable = 1'b1;
      do_init("reinit");

      // async reset while waiting for byte1
      send_rx(8'h08, 1'b0);
      reset = 1'b0;
      #2;
      chk("mid_rst_xy", 16'({x, y}), 16'({8'd80, 8'd60}));
      chk("mid_rst_flags", 16'({ready, packet_valid, l_click, r_click, m_click, bus.tx_valid}), 16'd0);
      mx = XM / 2; my = YM / 2;
      tick(3);
      txq.delete();
      reset = 1'b1;
      do_init("post_rst");
      pkt(8'h08, 8'h02, 8'h01, "post_rst_pkt");

      // no responses: three resets then permanent failure
      reset = 1'b0;
      tick(2);
      txq.delete();
      reset = 1'b1;
      expect_tx(8'hFF, "fail_try1");
      expect_tx(8'hFF, "fail_try2");
      expect_tx(8'hFF, "fail_try3");
      n = 0;
      while (init_fail !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
      chk("fail_flag", 16'(init_fail), 16'd1);
      chk("fail_tx_idle", 16'(bus.tx_valid), 16'd0);
      tick(3 * TO);
      chk("fail_no_more_tx", 16'(txq.size()), 16'd0);
      enable = 1'b0;
      tick(2);
      @(negedge clock);
      chk("fail_sticky", 16'(init_fail), 16'd1);

      // resend request re-issues the enable command
      reset = 1'b0;
      tick(2);
      txq.delete();
      reset = 1'b1; enable = 1'b1;
      expect_tx(8'hFF, "rs_rst");
      send_rx(8'hFA, 1'b0);
      send_rx(8'hAA, 1'b0);
      send_rx(8'h00, 1'b0);
`ifdef MOUSE_SAMPLE_RATE_EN
      expect_tx(8'hF3, "rs_rate");
      send_rx(8'hFA, 1'b0);
      expect_tx(8'd100, "rs_arg");
      send_rx(8'hFA, 1'b0);
`endif
      expect_tx(8'hF4, "rs_en1");
      send_rx(8'hFE, 1'b0);
      expect_tx(8'hF4, "rs_en2");
      send_rx(8'hFA, 1'b0);
      @(negedge clock);
      chk("rs_ready", 16'(ready), 16'd1);
      chk("rs_nofail", 16'(init_fail), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mouse_init_ctrl.md
Name: mouse_init_ctrl

Overview:
- Host-side sequencer for the PS/2 mouse link. It sits between a byte-level PS/2 transceiver and the game logic.
- Runs the power-up command sequence: reset, BAT/ID check, then enable data reporting. Retries on timeout or error.
- Once streaming, assembles 3-byte movement packets into a clamped cursor position (x, y) and button states on the 160x120 screen grid.

Parameters:
- X_MAX, 160, screen width; x range 0..X_MAX-1
- Y_MAX, 120, screen height; y range 0..Y_MAX-1
- TIMEOUT_CYCLES, 10_000_000, max clock cycles in any wait state (200 ms at 50 MHz)
- GAP_CYCLES, 100_000, max idle cycles between bytes of one packet (2 ms)
- RETRY_MAX, 3, init attempts before permanent failure
- SAMPLE_RATE, 8'd100, rate argument used only when MOUSE_SAMPLE_RATE_EN is defined

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  1: run; 0: return to S_IDLE
- tx_data  out  8  command byte to transceiver
- tx_valid  out  1  command byte offered
- tx_ready  in  1  transceiver accepts; transfer occurs when tx_valid && tx_ready
- rx_data  in  8  byte received from mouse
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_error  in  1  one-cycle pulse: parity or framing error on the received byte
- x  out  8  cursor column
- y  out  8  cursor row (0 = top)
- l_click, r_click, m_click  out  1 each  button states from the last good packet
- packet_valid  out  1  one-cycle pulse when x/y/click are updated
- ready  out  1  high while in S_STREAM
- init_fail  out  1  sticky; RETRY_MAX attempts exhausted

Behaviour:
- Reset values:
  - x = X_MAX/2 (80), y = Y_MAX/2 (60)
  - all clicks 0, packet_valid 0, ready 0, init_fail 0
  - tx_valid 0, tx_data 0
  - state S_IDLE, retry count 0
- States and transitions:
  - S_IDLE: waits for enable=1 → S_SEND_RST.
  - S_SEND_RST: tx_data=0xFF, tx_valid=1, held until the transfer cycle → S_WAIT_ACK_RST.
  - S_WAIT_ACK_RST: 0xFA → S_WAIT_BAT.
  - S_WAIT_BAT: 0xAA → S_WAIT_ID.
  - S_WAIT_ID: 0x00 → S_SEND_EN.
  - S_SEND_EN: sends 0xF4 → S_WAIT_ACK_EN.
  - S_WAIT_ACK_EN: 0xFA → S_STREAM, with ready=1 from the next cycle and retry count cleared.
- Failure in wait states:
  - Any of: unexpected byte, rx_error, or the wait-state counter reaching TIMEOUT_CYCLES.
  - Action: increment retry count, go to S_SEND_RST.
  - When retry count reaches RETRY_MAX, go to S_FAIL instead.
  - Exception: 0xFE (resend) in an ACK wait re-sends the same command and counts as one retry.
- Wait-state counter clears on every state change.
- If rx_valid and timeout occur in the same cycle, the received byte is evaluated and the timeout is ignored.
- Bytes received while in S_SEND_* or S_IDLE are discarded.
- S_FAIL: init_fail=1, tx_valid=0. Exits only on reset or enable=0 (S_IDLE; init_fail stays set until reset).
- enable=0 in any state:
  - Next state is S_IDLE; takes priority over a same-cycle tx transfer (tx_valid drops).
  - ready=0; x/y/clicks hold their values.
- S_STREAM packet assembly:
  - Byte index 0..2.
  - Byte0 is accepted only if bit3=1; otherwise it is discarded and the index stays 0 (resync).
  - rx_error or gap counter reaching GAP_CYCLES with index≠0 resets the index to 0 and drops the partial packet.
- On byte2 accepted (next cycle):
  - dx = {b0[4], b1}, dy = {b0[5], b2} (9-bit two's complement).
  - If b0[6] (x overflow) is set, dx is treated as 0; likewise b0[7] for dy.
  - x_next = clamp(x + dx, 0, X_MAX-1); y_next = clamp(y − dy, 0, Y_MAX-1). Use 11-bit signed intermediates.
  - l/r/m_click = b0[0]/b0[1]/b0[2].
  - packet_valid pulses for exactly 1 cycle.
- Total latency from the byte2 rx_valid cycle to the updated outputs: 1 cycle.

Optional Feature:
- Macro: MOUSE_SAMPLE_RATE_EN.
- Defined:
  - Between S_WAIT_ID and S_SEND_EN, insert S_SEND_RATE (0xF3) → S_WAIT_ACK_RATE → S_SEND_ARG (SAMPLE_RATE) → S_WAIT_ACK_ARG.
  - Each ACK wait expects 0xFA and follows the same failure and resend rules as the other wait states.
- Undefined: these states and the SAMPLE_RATE logic are absent; S_WAIT_ID goes directly to S_SEND_EN.

Decomposition:
- Package mouse_pkg holds:
  - state encoding constants
  - PS/2 command/response bytes (CMD_RESET 0xFF, CMD_ENABLE 0xF4, CMD_RATE 0xF3, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT_OK 0xAA, RSP_ID 0x00)
- One sub-module, mouse_packet_accum: 3-byte assembly, overflow masking and clamped position update.
- The sequencing FSM and timers remain in the top module.

Test Plan:
- Normal init: after reset release, enable=1; transceiver accepts 0xFF, returns FA, AA, 00; accepts 0xF4, returns FA → ready=1 and no init_fail.
- Movement: in S_STREAM send 0x08, 0x0A, 0x05 → x=90, y=55, clicks 0, packet_valid for 1 cycle.
- Clamp and buttons: send 0x19, 0x80 (dx=−128), 0x00 twice → x=0; send 0x09, 0x00, 0x00 → l_click=1.
- Resync and gap: send byte 0x00 (bit3=0) then a valid packet → only one packet_valid. Send byte0 then idle GAP_CYCLES → partial packet dropped; next valid packet applies normally.
- Failure path: no response after 0xFF for TIMEOUT_CYCLES, repeated → 0xFF sent 3 times total; init_fail=1 after the third timeout. FE after 0xF4 → 0xF4 re-sent.
- Reset mid-operation: assert reset during the byte1 wait → all outputs return to reset values immediately; the next init sequence runs cleanly.
